// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter (inhibit, request-to-send, 8 data bits, odd parity, stop, ACK check)
// Ports: clock/reset_n system clock and async active-low reset; data/send command byte and request;
// busy/done/error transaction status and completion pulses; ps_clock_i/ps_data_i raw pin levels;
// ps_clock_oe/ps_data_oe open-drain pull-low enables.
module ps2_tx #(
  parameter int CLK_HZ         = 25_000_000,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_CYCLES   = 25,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps_clock_i,
  input  logic       ps_data_i,
  output logic       ps_clock_oe,
  output logic       ps_data_oe
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] BITS      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  localparam int M1   = INHIBIT_CYCLES > START_CYCLES ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CMAX = TIMEOUT_CYCLES > M1 ? TIMEOUT_CYCLES : M1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FILTER_CYCLES + 1);

  if (CLK_HZ <= 0) begin : g_bad_clk
    $error("CLK_HZ must be positive");
  end

  // index 0 = clock line, index 1 = data line
  logic [1:0] s1_q, s2_q, filt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= {ps_data_i, ps_clock_i};
      s2_q <= s1_q;
    end

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [FW-1:0] cnt_q;
    logic          lvl_q;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else if (s2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FW'(FILTER_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= s2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    assign filt[g] = lvl_q;
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          data_oe_q, data_oe_d, done_q, done_d, error_q, error_d, clk_prev_q;
  logic          fall, tmo;

  // one cycle behind the filtered level, so data_oe moves 3+FILTER_CYCLES cycles after the raw edge
  assign fall = clk_prev_q & ~filt[0];
  assign tmo  = cnt_q == CW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    if (state_q == BITS || state_q == ACK || state_q == WAIT_IDLE) begin
      // a fall in the expiry cycle still counts as device activity
      if (fall) cnt_d = '0;
      else if (tmo) begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
        error_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE:
        if (send) begin
          state_d = INHIBIT;
          frame_d = {1'b1, ~^data, data};
          cnt_d   = '0;
          bit_d   = '0;
        end
      INHIBIT:
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d   = START;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      START:
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          state_d = BITS;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      BITS:
        if (fall) begin
          data_oe_d = ~frame_q[bit_q];
          bit_d     = bit_q + 1'b1;
          state_d   = bit_q == 4'd9 ? ACK : BITS;
        end
      ACK:
        if (fall) begin
          state_d   = filt[1] ? IDLE : WAIT_IDLE;
          error_d   = filt[1];
          data_oe_d = 1'b0;
        end
      WAIT_IDLE:
        if (filt[0] && filt[1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_prev_q <= filt[0];
    end

  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign error       = error_q;
  assign ps_clock_oe = state_q == INHIBIT || state_q == START;
  assign ps_data_oe  = data_oe_q;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with an open-drain PS/2 device model
module tb_ps2_tx;
  localparam int INH = 100;
  localparam int STA = 10;
  localparam int FIL = 8;
  localparam int TMO = 2000;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_GLITCH = 3;

  typedef struct packed {
    logic       ok;
    logic       chk_frame;
    logic [9:0] frame;
  } exp_t;

  logic       clock, reset_n, send, busy, done, error;
  logic       ps_clock_i, ps_data_i, ps_clock_oe, ps_data_oe;
  logic [7:0] data;
  logic       dev_clk, dev_dat;
  logic [9:0] dev_frame;
  int         dev_bit, dev_mode;
  int         nvec, nerr;
  exp_t       exp_q[$];

  ps2_tx #(
    .CLK_HZ(25_000_000), .INHIBIT_CYCLES(INH), .START_CYCLES(STA),
    .FILTER_CYCLES(FIL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .send(send),
    .busy(busy), .done(done), .error(error),
    .ps_clock_i(ps_clock_i), .ps_data_i(ps_data_i),
    .ps_clock_oe(ps_clock_oe), .ps_data_oe(ps_data_oe)
  );

  assign ps_clock_i = dev_clk & ~ps_clock_oe;
  assign ps_data_i  = dev_dat & ~ps_data_oe;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dev_run();
    dev_frame = '0;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 11 && busy; i++) begin
      dev_bit = i;
      if (i == 10) begin
        dev_dat = dev_mode == M_NACK;
        repeat (5) @(negedge clock);
      end
      dev_clk = 1'b0;
      repeat (30) @(negedge clock);
      if (i < 10) dev_frame[i] = ps_data_i;
      dev_clk = 1'b1;
      if (dev_mode == M_GLITCH && i == 4) begin
        repeat (10) @(negedge clock);
        dev_clk = 1'b0;
        repeat (4) @(negedge clock);
        dev_clk = 1'b1;
        repeat (16) @(negedge clock);
      end else repeat (30) @(negedge clock);
    end
    dev_dat = 1'b1;
    dev_bit = -1;
  endtask

  initial begin
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    dev_bit = -1;
    dev_frame = '0;
    forever begin
      @(negedge clock);
      if (reset_n && busy && !ps_clock_oe && ps_data_oe && dev_mode != M_SILENT) dev_run();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done || error) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, done, error}, e.ok ? 32'd2 : 32'd1);
          chk("lines_released", {30'd0, ps_clock_oe, ps_data_oe}, 32'd0);
          if (e.chk_frame) chk("frame", {22'd0, dev_frame}, {22'd0, e.frame});
        end
      end
    end
  end

  task automatic xfer(input logic [7:0] b, input int mode, input logic hold, input logic [9:0] frame);
    int k;
    dev_mode = mode;
    exp_q.push_back('{mode == M_ACK || mode == M_GLITCH, mode != M_SILENT, frame});
    @(negedge clock);
    data = b;
    send = 1'b1;
    @(posedge clock); #1;
    chk("accept", {29'd0, busy, ps_clock_oe, ps_data_oe}, 32'd6);
    if (!hold) send = 1'b0;
    k = 0;
    while (!ps_data_oe && k < 5000) begin @(posedge clock); #1; k++; end
    chk("inhibit_len", k, INH);
    k = 0;
    while (ps_clock_oe && k < 5000) begin @(posedge clock); #1; k++; end
    chk("start_len", k, STA);
    send = 1'b0;
    k = 0;
    if (mode == M_SILENT) begin
      while (!error && k < TMO + 50) begin @(posedge clock); #1; k++; end
      chk("timeout_len", k, TMO);
    end else begin
      while (busy && k < 3000) begin @(posedge clock); #1; k++; end
      chk("complete", {31'd0, busy}, 32'd0);
    end
    repeat (5) @(negedge clock);
  endtask

  initial begin
    int k;
    nvec = 0;
    nerr = 0;
    dev_mode = M_ACK;
    reset_n = 1'b0;
    send = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset_state", {27'd0, busy, done, error, ps_clock_oe, ps_data_oe}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    xfer(8'hED, M_ACK, 1'b0, 10'h3ED);
    xfer(8'h01, M_ACK, 1'b0, 10'h201);
    xfer(8'h00, M_ACK, 1'b0, 10'h300);
    xfer(8'hFF, M_ACK, 1'b0, 10'h3FF);
    xfer(8'hA5, M_NACK, 1'b0, 10'h3A5);
    xfer(8'hF4, M_SILENT, 1'b0, 10'h000);
    xfer(8'h3C, M_GLITCH, 1'b1, 10'h33C);
    dev_mode = M_ACK;
    @(negedge clock);
    data = 8'h55;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    k = 0;
    while (dev_bit != 5 && k < 3000) begin @(negedge clock); k++; end
    chk("reach_bit5", dev_bit, 5);
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {29'd0, busy, ps_clock_oe, ps_data_oe}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    while (dev_bit != -1 && k < 3000) begin @(negedge clock); k++; end
    chk("device_idle", dev_bit, -1);
    repeat (20) @(negedge clock);
    xfer(8'hFF, M_ACK, 1'b0, 10'h3FF);
    repeat (50) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
